// File: rtl/proc_io_queue.sv
// proc_io_queue: tags proc I/O strobes into a FIFO drained over valid/ready, with sticky drop status.
module proc_io_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sac,
  input  logic                       snd,
  input  logic                       uad,
  input  logic                       ppu_send,
  input  logic [DATA_W-1:0]          interface_data,
  output logic                       io_stall,
  output logic                       out_valid,
  output logic [1:0]                 out_tag,
  output logic [DATA_W-1:0]          out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       multi_strobe,
  output logic [CNT_W-1:0]           drop_cnt,
  input  logic                       clr_status
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W+1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d, multi_q, multi_d;
  logic [CNT_W-1:0] drop_q, drop_d, drop_base;
  logic push, pop, full, wr_en, drop;
  logic [1:0] tag;
  always_comb begin
    push      = sac | snd | uad | ppu_send;
    tag       = ppu_send ? 2'd3 : snd ? 2'd1 : sac ? 2'd0 : 2'd2;
    out_valid = count_q != '0;
    pop       = out_valid & out_ready;
    full      = count_q == CW'(DEPTH);
    wr_en     = push & (!full | pop);
    drop      = push & full & !pop;
    wr_ptr_d  = wr_ptr_q + AW'(wr_en);
    rd_ptr_d  = rd_ptr_q + AW'(pop);
    count_d   = count_q + CW'(wr_en) - CW'(pop);
    overflow_d = drop | (!clr_status & overflow_q);
    multi_d   = ($countones({sac, snd, uad, ppu_send}) > 1) | (!clr_status & multi_q);
    drop_base = clr_status ? '0 : drop_q;
    drop_d    = (drop & !(&drop_base)) ? drop_base + CNT_W'(1) : drop_base;
    out_tag   = out_valid ? mem_q[rd_ptr_q][DATA_W+:2] : 2'd0;
    out_data  = out_valid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
    io_stall  = count_q >= CW'(DEPTH - 1);
    count     = count_q;
    overflow  = overflow_q;
    multi_strobe = multi_q;
    drop_cnt  = drop_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      multi_q    <= 1'b0;
      drop_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      multi_q    <= multi_d;
      drop_q     <= drop_d;
    end
  end
  always_ff @(posedge clk) if (wr_en) mem_q[wr_ptr_q] <= {tag, interface_data};
endmodule

// File: tb/tb_proc_io_queue.sv
// tb_proc_io_queue: priority vector table plus scoreboard-checked FIFO sequences.
module tb_proc_io_queue;
  logic clk = 0, rst = 1, sac = 0, snd = 0, uad = 0, ppu_send = 0, out_ready = 0, clr_status = 0;
  logic [31:0] interface_data = 0, out_data;
  logic io_stall, out_valid, overflow, multi_strobe;
  logic [1:0] out_tag;
  logic [3:0] count;
  logic [7:0] drop_cnt;
  int checks = 0, failures = 0;
  logic [33:0] sb[$];
  logic m_ovf = 0, m_multi = 0;
  int m_drop = 0;
  typedef struct {logic [3:0] s; logic [31:0] d; logic [1:0] tag; logic multi;} vec_t;
  vec_t vt[8];
  proc_io_queue dut (
    .clk(clk), .rst(rst), .sac(sac), .snd(snd), .uad(uad), .ppu_send(ppu_send),
    .interface_data(interface_data), .io_stall(io_stall), .out_valid(out_valid),
    .out_tag(out_tag), .out_data(out_data), .out_ready(out_ready), .count(count),
    .overflow(overflow), .multi_strobe(multi_strobe), .drop_cnt(drop_cnt),
    .clr_status(clr_status)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  function automatic logic [1:0] prio(input logic [3:0] s);
    return s[3] ? 2'd3 : s[1] ? 2'd1 : s[0] ? 2'd0 : 2'd2;
  endfunction
  // s = {ppu_send, uad, snd, sac}; called at a negedge, returns at the next negedge
  task automatic step(input logic [3:0] s, input logic [31:0] d, input logic r, input logic c);
    logic pop_m;
    chk("count", 64'(count), 64'(sb.size()));
    chk("out_valid", 64'(out_valid), 64'(sb.size() != 0));
    chk("io_stall", 64'(io_stall), 64'(sb.size() >= 7));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("multi_strobe", 64'(multi_strobe), 64'(m_multi));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    {ppu_send, uad, snd, sac} = s;
    interface_data = d;
    out_ready = r;
    clr_status = c;
    pop_m = r && sb.size() != 0;
    if (pop_m) begin
      chk("head_tag", 64'(out_tag), 64'(sb[0][33:32]));
      chk("head_data", 64'(out_data), 64'(sb[0][31:0]));
    end
    if (c) begin
      m_ovf = 0;
      m_multi = 0;
      m_drop = 0;
    end
    if ($countones(s) > 1) m_multi = 1;
    if (pop_m) void'(sb.pop_front());
    if (s != 0) begin
      if (sb.size() < 8) sb.push_back({prio(s), d});
      else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    {ppu_send, uad, snd, sac} = 4'b0;
    out_ready = 0;
    clr_status = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    sb.delete();
    m_ovf = 0;
    m_multi = 0;
    m_drop = 0;
  endtask
  task automatic drain();
    for (int i = 0; i < 10; i++) step(4'b0, 32'h0, 1'b1, 1'b0);
  endtask
  initial begin
    vt[0] = '{4'b0001, 32'h11, 2'd0, 1'b0};
    vt[1] = '{4'b0010, 32'h22, 2'd1, 1'b0};
    vt[2] = '{4'b0100, 32'h33, 2'd2, 1'b0};
    vt[3] = '{4'b1000, 32'h44, 2'd3, 1'b0};
    vt[4] = '{4'b1101, 32'h55, 2'd3, 1'b1};
    vt[5] = '{4'b0011, 32'h66, 2'd1, 1'b1};
    vt[6] = '{4'b0101, 32'h77, 2'd0, 1'b1};
    vt[7] = '{4'b0110, 32'h88, 2'd1, 1'b1};
    @(negedge clk);
    do_reset();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_tag", 64'(out_tag), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_io_stall", 64'(io_stall), 64'(0));
    // single push with ready held high
    step(4'b0001, 32'hDEADBEEF, 1'b1, 1'b0);
    step(4'b0000, 32'h0, 1'b1, 1'b0);
    step(4'b0000, 32'h0, 1'b1, 1'b0);
    // fill, overflow, push+pop while full, drain
    for (int i = 1; i <= 8; i++) step(4'b0010, 32'(i), 1'b0, 1'b0);
    chk("full_stall", 64'(io_stall), 64'(1));
    step(4'b0010, 32'hBAD, 1'b0, 1'b0);
    chk("ovf_set", 64'(overflow), 64'(1));
    chk("drop_one", 64'(drop_cnt), 64'(1));
    step(4'b0010, 32'd9, 1'b1, 1'b0);
    chk("full_pushpop_count", 64'(count), 64'(8));
    drain();
    // priority table
    step(4'b0000, 32'h0, 1'b0, 1'b1);
    foreach (vt[i]) begin
      step(vt[i].s, vt[i].d, 1'b0, 1'b0);
      chk("vec_tag", 64'(out_tag), 64'(vt[i].tag));
      chk("vec_data", 64'(out_data), 64'(vt[i].d));
      chk("vec_multi", 64'(multi_strobe), 64'(vt[i].multi));
      step(4'b0000, 32'h0, 1'b1, 1'b1);
    end
    chk("multi_cleared", 64'(multi_strobe), 64'(0));
    // clear coinciding with a new multi event keeps the flag
    step(4'b1001, 32'hA5, 1'b0, 1'b1);
    chk("clr_vs_multi", 64'(multi_strobe), 64'(1));
    drain();
    // reset mid-operation, then random push/pop across pointer wrap
    for (int i = 0; i < 3; i++) step(4'b0100, 32'(100 + i), 1'b0, 1'b0);
    do_reset();
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_valid", 64'(out_valid), 64'(0));
    chk("midrst_stall", 64'(io_stall), 64'(0));
    step(4'b0000, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      int k = $urandom_range(0, 4);
      step(k == 4 ? 4'b0 : 4'(1 << k), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    drain();
    // drop counter saturation
    step(4'b0000, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(4'b1000, 32'(200 + i), 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step(4'b0001, 32'(i), 1'b0, 1'b0);
    chk("drop_sat", 64'(drop_cnt), 64'(255));
    step(4'b0001, 32'h0, 1'b0, 1'b1);
    chk("clr_vs_drop_cnt", 64'(drop_cnt), 64'(1));
    chk("clr_vs_drop_ovf", 64'(overflow), 64'(1));
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
